rr_onehot_arb: RTL and testbench

RR_ONEHOT_ARB -- requirements
Module: rr_onehot_arb

---
 rtl/rr_onehot_arb.sv | 126 ++++++++++++
 tb/tb_rr_onehot_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter with a registered one-hot grant held under a valid/ready hand-off.
// Define RR_ONEHOT_ARB_LOCK_EN to let lock=1 hold the current grant across transfers (bursts).
module rr_onehot_arb #(
    parameter int N_CH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            lock,
    output logic [N_CH-1:0] gnt_onehot,
    output logic [7:0]      gnt_idx,
    output logic            gnt_valid,
    input  logic            gnt_ready,
    output logic            o_dbg_state
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_CH-1:0]  r_onehot;
    logic [N_CH-1:0]  w_onehot_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_last_nxt;
    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_pick;
    logic [N_CH-1:0]  w_pick_oh;
    logic             w_found;
    logic             w_xfer;
    logic             w_hold;

    // Handshake: a transfer happens on an edge where gnt_valid && gnt_ready; otherwise the grant is frozen.
    assign w_xfer = (r_state == GRANT) && gnt_ready;

`ifdef RR_ONEHOT_ARB_LOCK_EN
    assign w_hold = lock;
`else
    assign w_hold = lock & 1'b0;
`endif

    // On a transfer the search starts just past the channel being released; that channel comes last,
    // so it is re-granted only when nobody else is requesting.
    assign w_base = w_xfer ? r_idx : r_last;

    always_comb begin
        int c;
        w_found = 1'b0;
        w_pick  = '0;
        c       = 0;
        for (int k = 1; k <= N_CH; k++) begin
            c = int'(w_base) + k;
            if (c >= N_CH) begin
                c = c - N_CH;
            end
            if (!w_found && req[c[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = c[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_pick_oh         = '0;
        w_pick_oh[w_pick] = 1'b1;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_onehot_nxt = r_onehot;
        w_idx_nxt    = r_idx;
        w_last_nxt   = r_last;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt  = GRANT;
                    w_onehot_nxt = w_pick_oh;
                    w_idx_nxt    = w_pick;
                end
            end
            GRANT: begin
                if (w_xfer && !w_hold) begin
                    w_last_nxt = r_idx;
                    if (w_found) begin
                        w_onehot_nxt = w_pick_oh;
                        w_idx_nxt    = w_pick;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_onehot_nxt = '0;
                        w_idx_nxt    = '0;
                    end
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_onehot_nxt = '0;
                w_idx_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_onehot <= '0;
            r_idx    <= '0;
            r_last   <= IDX_W'(N_CH - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_onehot <= w_onehot_nxt;
            r_idx    <= w_idx_nxt;
            r_last   <= w_last_nxt;
        end
    end

    assign gnt_onehot  = r_onehot;
    assign gnt_idx     = 8'(r_idx);
    assign gnt_valid   = (r_state == GRANT);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Bench for rr_onehot_arb: directed scenarios plus random traffic against a queue-based reference,
// with the grant steering an 8x8-bit one-hot mux.
module tb_rr_onehot_arb;
    localparam int N = 8;
    localparam int W = 1 + N + 8 + 8;
`ifdef RR_ONEHOT_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         lock;
    logic [N-1:0] gnt_onehot;
    logic [7:0]   gnt_idx;
    logic         gnt_valid;
    logic         gnt_ready;
    logic         dbg_state;
    logic [7:0]   mux_out;
    logic [7:0]   mux_in [N];

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];

    bit           m_valid;
    int           m_idx;
    int           m_last;

    // clock / reset
    always #5 clk = ~clk;

    rr_onehot_arb #(.N_CH(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .lock        (lock),
        .gnt_onehot  (gnt_onehot),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .gnt_ready   (gnt_ready),
        .o_dbg_state (dbg_state)
    );

    always_comb begin
        mux_out = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (gnt_onehot[i]) mux_out = mux_out | mux_in[i];
        end
    end

    // reference: first set bit of mask found walking upward from start, wrapping
    function automatic int rr_from(input logic [N-1:0] mask, input int start);
        for (int off = 0; off < N; off++) begin
            if (mask[(start + off) % N]) return (start + off) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input logic [N-1:0] rq, input bit lk, input bit rdy);
        logic [N-1:0] others;
        if (r) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_last  = N - 1;
        end else if (!m_valid) begin
            if (rq != '0) begin
                m_idx   = rr_from(rq, (m_last + 1) % N);
                m_valid = 1'b1;
            end
        end else if (rdy && !(LOCK_EN && lk)) begin
            m_last         = m_idx;
            others         = rq;
            others[m_idx]  = 1'b0;
            if (others != '0) begin
                m_idx = rr_from(others, (m_idx + 1) % N);
            end else if (!rq[m_idx]) begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
    endtask

    task automatic push_expected();
        logic [N-1:0] oh;
        logic [7:0]   data;
        oh   = '0;
        data = 8'h00;
        if (m_valid) begin
            oh[m_idx] = 1'b1;
            data      = mux_in[m_idx];
        end
        exp_q.push_back({m_valid, oh, 8'(m_idx), data});
    endtask

    // driver: inputs change on the falling edge, expectation for the next rising edge is queued
    task automatic drive(input bit r, input logic [N-1:0] rq, input bit lk, input bit rdy);
        @(negedge clk);
        rst       = r;
        req       = rq;
        lock      = lk;
        gnt_ready = rdy;
        model_step(r, rq, lk, rdy);
        push_expected();
    endtask

    task automatic do_reset();
        drive(1'b1, '0, 1'b0, 1'b0);
        drive(1'b1, '0, 1'b0, 1'b0);
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                act_v = {gnt_valid, gnt_onehot, gnt_idx, mux_out};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL grant @%0t: got v=%0b oh=%b idx=%0d mux=%h, exp v=%0b oh=%b idx=%0d mux=%h",
                             $time, act_v[W-1], act_v[W-2 -: N], act_v[15:8], act_v[7:0],
                             exp_v[W-1], exp_v[W-2 -: N], exp_v[15:8], exp_v[7:0]);
                end
                checks++;
                if (dbg_state !== exp_v[W-1]) begin
                    errors++;
                    $display("FAIL dbg_state @%0t: got %0b exp %0b", $time, dbg_state, exp_v[W-1]);
                end
            end
        end
    end

    initial begin
        mux_in[0] = 8'haa; mux_in[1] = 8'hbb; mux_in[2] = 8'hcc; mux_in[3] = 8'hdd;
        mux_in[4] = 8'hee; mux_in[5] = 8'hff; mux_in[6] = 8'h11; mux_in[7] = 8'h22;
        rst       = 1'b1;
        req       = '0;
        lock      = 1'b0;
        gnt_ready = 1'b0;
        m_valid   = 1'b0;
        m_idx     = 0;
        m_last    = N - 1;

        do_reset();
        repeat (2) drive(1'b0, '0, 1'b0, 1'b1);

        // two requesters alternate: 1, 2, 1
        do_reset();
        repeat (4) drive(1'b0, 8'b0000_0110, 1'b0, 1'b1);

        // all requesting, no bubbles: 0..7,0,1
        do_reset();
        repeat (10) drive(1'b0, 8'hff, 1'b0, 1'b1);

        // ch5 granted, consumer stalls while req drops, then releases to idle
        do_reset();
        drive(1'b0, 8'b0010_0000, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // reset during a grant on ch3 (with a transfer), then ch0 wins first
        do_reset();
        drive(1'b0, 8'b0000_1000, 1'b0, 1'b0);
        drive(1'b0, 8'b0000_1000, 1'b0, 1'b0);
        drive(1'b1, 8'b0000_1000, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 8'b0000_1001, 1'b0, 1'b1);

        // lock held for three transfers on ch2, then released
        do_reset();
        repeat (4) drive(1'b0, 8'b0010_0100, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 8'b0010_0100, 1'b0, 1'b1);

        // mux end to end: aa, ff, aa
        do_reset();
        repeat (3) drive(1'b0, 8'b0010_0001, 1'b0, 1'b1);

        // random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] rq;
            rq = N'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) rq = '0;
            if ($urandom_range(0, 3) == 0) rq = rq & N'($urandom_range(0, 255));
            drive(($urandom_range(0, 49) == 0), rq, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0));
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
